// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared MDOp encodings, default latencies and helpers for the EX-stage multiply/divide unit.
//   MD_* opcodes      : 4-bit MDOp values used by decoder, hazard unit and md_unit
//   MD_*_CYCLES       : default busy lengths after a mult/div start
//   md_pair_t         : {hi, lo} result pair
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_pair_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit with HI/LO registers and a Busy flag for the hazard unit.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   A, B   in  forwarded rs/rt operands
//   MDOp   in  operation select (none/mult/multu/div/divu/mthi/mtlo/mfhi/mflo)
//   Start  in  one-cycle pulse launching mult/multu/div/divu
//   Req    in  CP0 request; cancels this cycle's start and mthi/mtlo
//   Busy   out start accepted this cycle or an operation still counting
//   HI, LO out architectural HI/LO registers
//   MDOut  out HI for mfhi, LO for mflo, else 0
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    logic [3:0]         count;
    md_pair_t           pending;
    logic               commit;
    md_pair_t           calc;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dvs;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               ovf;
    logic               start_go;
    logic               idle_write;

    // A zero divisor is swapped for 1 so the dividers never produce X; the
    // result is discarded anyway because commit is cleared for that case.
    // 0x80000000 / -1 overflows the signed quotient, so it is pinned explicitly.
    always_comb begin
        dvs    = (B == 32'd0) ? 32'd1 : B;
        ovf    = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        quo_s  = ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(dvs));
        rem_s  = ovf ? 32'd0 : 32'($signed(A) % $signed(dvs));
        quo_u  = A / dvs;
        rem_u  = A % dvs;
        calc   = MDOp == MD_MULT  ? md_pair_t'(prod_s) :
                 MDOp == MD_MULTU ? md_pair_t'(prod_u) :
                 MDOp == MD_DIV   ? md_pair_t'({rem_s, quo_s}) :
                                    md_pair_t'({rem_u, quo_u});
    end

    assign start_go   = Start && !Req && count == 4'd0 && is_long_op(MDOp);
    assign idle_write = !Req && count == 4'd0;
    assign Busy       = start_go || count != 4'd0;
    assign MDOut      = MDOp == MD_MFHI ? HI : MDOp == MD_MFLO ? LO : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= 4'd0;
            pending <= '0;
            commit  <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
            if (count == 4'd1 && commit) begin
                HI <= pending.hi;
                LO <= pending.lo;
            end
        end else if (start_go) begin
            pending <= calc;
            commit  <= !(is_div_op(MDOp) && B == 32'd0);
            count   <= is_div_op(MDOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (idle_write && MDOp == MD_MTHI) begin
            HI <= A;
        end else if (idle_write && MDOp == MD_MTLO) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  MDOp = MD_NONE;
    logic        Start = 1'b0;
    logic        Req = 1'b0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int compared = 0;
    int mismatched = 0;
    logic [63:0] exp_q[$];

    md_unit dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
        .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1. req_at>0 raises Req during that busy cycle.
    task automatic md_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int cycles,
                         input int req_at);
        int n;
        logic [63:0] e;
        check({tag, "_idle"}, {31'd0, Busy}, 32'd0);
        exp_q.push_back(exp);
        A = a; B = b; MDOp = op; Start = 1'b1;
        @(negedge clk);
        check({tag, "_busy_start"}, {31'd0, Busy}, 32'd1);
        @(posedge clk); #1;
        Start = 1'b0; MDOp = MD_NONE; n = 1;
        while (n < 40) begin
            @(negedge clk);
            Req = 1'b0;
            if (!Busy) break;
            n++;
            if (n == req_at) Req = 1'b1;
        end
        Req = 1'b0;
        check({tag, "_busy_len"}, 32'(n), 32'(cycles));
        e = exp_q.pop_front();
        check({tag, "_hi"}, HI, e[63:32]);
        check({tag, "_lo"}, LO, e[31:0]);
        @(posedge clk); #1;
    endtask

    task automatic mt_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic req);
        A = a; MDOp = op; Req = req;
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        MDOp = MD_NONE; Req = 1'b0;
    endtask

    task automatic mf_check(input string tag, input logic [3:0] op, input logic [31:0] exp);
        MDOp = op;
        @(negedge clk);
        check(tag, MDOut, exp);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        MDOp = MD_NONE;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_mdout", MDOut, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        md_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 6, 0);
        md_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 6, 0);
        md_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 6, 0);
        md_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 11, 0);
        md_op("divu", MD_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 11, 0);
        md_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 11, 0);
        md_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 11, 0);

        mt_op("mthi", MD_MTHI, 32'h1234, 1'b0);
        mt_op("mtlo", MD_MTLO, 32'h5678, 1'b0);
        mf_check("mfhi", MD_MFHI, 32'h1234);
        mf_check("mflo", MD_MFLO, 32'h5678);

        mt_op("mthi_aa", MD_MTHI, 32'hAA, 1'b0);
        mt_op("mtlo_bb", MD_MTLO, 32'hBB, 1'b0);
        md_op("div0", MD_DIV, 32'd99, 32'd0, 64'h0000_00AA_0000_00BB, 11, 0);
        md_op("divu0", MD_DIVU, 32'd99, 32'd0, 64'h0000_00AA_0000_00BB, 11, 0);

        A = 32'd3; B = 32'd4; MDOp = MD_MULT; Start = 1'b1; Req = 1'b1;
        @(negedge clk);
        check("req_start_busy", {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        Start = 1'b0; MDOp = MD_NONE; Req = 1'b0;
        @(negedge clk);
        check("req_start_busy_after", {31'd0, Busy}, 32'd0);
        check("req_start_hi", HI, 32'hAA);
        check("req_start_lo", LO, 32'hBB);
        @(posedge clk); #1;

        md_op("mult_req_mid", MD_MULT, 32'd6, 32'd7, 64'd42, 6, 3);

        mt_op("mtlo_req", MD_MTLO, 32'hDEAD, 1'b1);
        mf_check("mtlo_req_lo", MD_MFLO, 32'd42);

        mf_check("mfhi_during_pre", MD_MFHI, 32'd0);
        A = 32'd100; B = 32'd3; MDOp = MD_DIV; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; MDOp = MD_MFLO;
        @(negedge clk);
        check("mflo_while_busy", MDOut, 32'd42);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        MDOp = MD_NONE;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        md_op("mult_after_rst", MD_MULT, 32'd3, 32'd4, 64'd12, 6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
